// File: rtl/counter9999_core.sv
// counter9999_core: run/stop counter 0..MAX_VAL with a prescaler and tick/wrap strobes.
// Define COUNTER_DOWN_EN to build the i_dir down-count path (otherwise up-only).
module counter9999_core #(
    parameter int SYS_CLK_HZ = 100_000_000,
    parameter int TICK_HZ    = 10,
    parameter int MAX_VAL    = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_run_toggle,
    input  logic        i_clear,
    input  logic        i_dir,
    output logic [13:0] o_count,
    output logic        o_running,
    output logic        o_tick,
    output logic        o_wrap
);
    localparam int DIV = SYS_CLK_HZ / TICK_HZ;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [13:0] MAX = 14'(MAX_VAL);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $fatal(1, "counter9999_core: SYS_CLK_HZ/TICK_HZ must be >= 2");
    end
    if (MAX_VAL > 16383 || MAX_VAL < 1) begin : g_bad_max
        $fatal(1, "counter9999_core: MAX_VAL must be in 1..16383");
    end

    typedef enum logic {STOP, RUN} state_t;

    state_t        state;
    logic [PW-1:0] psc;
    logic          step;
    logic          down;
    logic          at_end;
    logic [13:0]   count_nx;

`ifdef COUNTER_DOWN_EN
    assign down = i_dir;
`else
    logic unused_dir;
    assign unused_dir = i_dir;
    assign down = 1'b0;
`endif

    always_comb begin
        step     = (state == RUN) && (psc == LAST);
        at_end   = down ? (o_count == 14'd0) : (o_count == MAX);
        count_nx = at_end ? (down ? MAX : 14'd0) : (down ? o_count - 14'd1 : o_count + 14'd1);
    end

    // Clear beats the step, and the step uses the pre-toggle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= STOP;
            psc       <= '0;
            o_count   <= '0;
            o_running <= 1'b0;
            o_tick    <= 1'b0;
            o_wrap    <= 1'b0;
        end else if (i_clear) begin
            state     <= STOP;
            psc       <= '0;
            o_count   <= '0;
            o_running <= 1'b0;
            o_tick    <= 1'b0;
            o_wrap    <= 1'b0;
        end else begin
            state     <= i_run_toggle ? ((state == RUN) ? STOP : RUN) : state;
            o_running <= i_run_toggle ^ (state == RUN);
            psc       <= (state == RUN) ? ((psc == LAST) ? '0 : psc + 1'b1) : psc;
            o_tick    <= step;
            o_wrap    <= step && at_end;
            if (step)
                o_count <= count_nx;
        end
    end
endmodule

// File: tb/tb_counter9999_core.sv
// tb_counter9999_core: randomized and directed checks of counter9999_core against a cycle-count model.
module tb_counter9999_core;
    localparam int DIV  = 10;
    localparam int MAXV = 9999;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tog = 1'b0, clr = 1'b0, dir = 1'b0;
    logic [13:0] count;
    logic        running, tick, wrap;
    logic        f_tog = 1'b0;
    logic [13:0] f_count;
    logic        f_running, f_tick, f_wrap;

    int checks = 0;
    int failures = 0;
    int m_cnt = 0, m_rc = 0;
    bit m_run = 0, m_tick = 0, m_wrap = 0;

    counter9999_core #(.SYS_CLK_HZ(10), .TICK_HZ(1), .MAX_VAL(MAXV)) dut (
        .clk(clk), .rst_n(rst_n), .i_run_toggle(tog), .i_clear(clr), .i_dir(dir),
        .o_count(count), .o_running(running), .o_tick(tick), .o_wrap(wrap)
    );

    counter9999_core #(.SYS_CLK_HZ(2), .TICK_HZ(1), .MAX_VAL(MAXV)) dut_fast (
        .clk(clk), .rst_n(rst_n), .i_run_toggle(f_tog), .i_clear(1'b0), .i_dir(1'b0),
        .o_count(f_count), .o_running(f_running), .o_tick(f_tick), .o_wrap(f_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_all(input string tag);
        check({tag, ".count"}, 32'(count), 32'(m_cnt));
        check({tag, ".running"}, 32'(running), 32'(m_run));
        check({tag, ".tick"}, 32'(tick), 32'(m_tick));
        check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    endtask

    // Model: count advances once every DIV cycles spent in RUN since the last clear.
    task automatic cyc(input bit t, input bit c, input bit d, input string tag = "cyc");
        bit dn;
`ifdef COUNTER_DOWN_EN
        dn = d;
`else
        dn = 1'b0;
`endif
        tog = t; clr = c; dir = d;
        @(posedge clk);
        if (c) begin
            m_cnt = 0; m_rc = 0; m_run = 0; m_tick = 0; m_wrap = 0;
        end else begin
            m_tick = 0; m_wrap = 0;
            if (m_run) begin
                m_rc++;
                if (m_rc % DIV == 0) begin
                    m_tick = 1;
                    m_wrap = dn ? (m_cnt == 0) : (m_cnt == MAXV);
                    m_cnt = dn ? (m_cnt + MAXV) % (MAXV + 1) : (m_cnt + 1) % (MAXV + 1);
                end
            end
            if (t) m_run = !m_run;
        end
        #1;
        tog = 1'b0; clr = 1'b0;
        cmp_all(tag);
    endtask

    initial begin
        int n;
        int wraps;
        bit reached;
        repeat (2) @(posedge clk);
        #1;
        cmp_all("reset");
        rst_n = 1'b1;

        cyc(1, 0, 0, "start");
        check("start_running", 32'(running), 32'd1);
        repeat (10) cyc(0, 0, 0, "first");
        check("count_at_10", 32'(count), 32'd1);
        check("tick_at_10", 32'(tick), 32'd1);
        repeat (10) cyc(0, 0, 0, "second");
        check("count_at_20", 32'(count), 32'd2);

        repeat (3) cyc(0, 0, 0, "pre_stop");
        cyc(1, 0, 0, "stop");
        repeat (50) cyc(0, 0, 0, "stopped");
        check("held_count", 32'(count), 32'd2);
        cyc(1, 0, 0, "resume");
        n = 0;
        do begin
            cyc(0, 0, 0, "resumed");
            n++;
        end while (!tick && n < 20);
        check("resume_latency", 32'(n), 32'd6);

        n = 0;
        while (m_cnt != 123 && n < 2000) begin
            cyc(0, 0, 0, "to123");
            n++;
        end
        check("reach_123", 32'(count), 32'd123);
        cyc(1, 1, 0, "clr_tog");
        check("clr_tog_count", 32'(count), 32'd0);
        check("clr_tog_running", 32'(running), 32'd0);
        check("clr_tog_tick", 32'(tick), 32'd0);

        cyc(1, 0, 1, "dir_start");
        repeat (10) cyc(0, 0, 1, "dir_run");
`ifdef COUNTER_DOWN_EN
        check("dir_count", 32'(count), 32'd9999);
        check("dir_wrap", 32'(wrap), 32'd1);
`else
        check("dir_count", 32'(count), 32'd1);
        check("dir_wrap", 32'(wrap), 32'd0);
`endif

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 24) == 0, $urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), "rand");

        cyc(0, 1, 0, "clr500");
        cyc(1, 0, 0, "run500");
        n = 0;
        while (m_cnt != 500 && n < 6000) begin
            cyc(0, 0, 0, "to500");
            n++;
        end
        check("reach_500", 32'(count), 32'd500);
        repeat (3) cyc(0, 0, 0, "at500");
        #2 rst_n = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_running", 32'(running), 32'd0);
        check("async_tick", 32'(tick), 32'd0);
        check("async_wrap", 32'(wrap), 32'd0);
        m_cnt = 0; m_rc = 0; m_run = 0; m_tick = 0; m_wrap = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) cyc(0, 0, 0, "post_reset");

        f_tog = 1'b1;
        @(posedge clk);
        #1 f_tog = 1'b0;
        wraps = 0;
        reached = 0;
        for (int i = 0; i < 25000; i++) begin
            @(posedge clk);
            #1;
            if (f_wrap) wraps++;
            if (f_tick && f_count == 14'd9998) begin
                reached = 1;
                break;
            end
        end
        check("fast_reach_9998", 32'(reached), 32'd1);
        check("fast_no_early_wrap", 32'(wraps), 32'd0);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!f_tick && n < 5);
            check("fast_tick_seen", 32'(f_tick), 32'd1);
            check("fast_count", 32'(f_count), (k == 0) ? 32'd9999 : 32'd0);
            check("fast_wrap", 32'(f_wrap), (k == 0) ? 32'd0 : 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/counter9999_core.md
# counter9999_core

Free-running BCD-range counter (0..9999) with a run/stop control state machine and a parameterised prescaler. It produces the 14-bit binary count consumed by the four-digit FND controller (`in_val`) in the counter9999 design. It also provides tick and wrap strobes for downstream status logic.

## Interface
Parameters:
- `SYS_CLK_HZ`, 100_000_000: input clock frequency.
- `TICK_HZ`, 10: count rate. `DIV = SYS_CLK_HZ / TICK_HZ`, which must be >= 2 (checked by elaboration-time assertion).
- `MAX_VAL`, 9999: terminal count. Must be <= 16383.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `i_run_toggle`, in, 1: single-cycle pulse that toggles run/stop.
- `i_clear`, in, 1: single-cycle pulse that clears the count and stops.
- `i_dir`, in, 1: 0 = up, 1 = down. Only sampled when `COUNTER_DOWN_EN` is defined.
- `o_count`, out, 14: current count, binary, range 0..MAX_VAL.
- `o_running`, out, 1: high in RUN state.
- `o_tick`, out, 1: one-cycle strobe, coincident with each count change.
- `o_wrap`, out, 1: one-cycle strobe, coincident with a wrap-around count change.

Reset values of all outputs: `o_count`=0, `o_running`=0, `o_tick`=0, `o_wrap`=0.

## Operation
- Two-state FSM:
  - STOP (reset state): `i_run_toggle` -> RUN.
  - RUN: `i_run_toggle` -> STOP; `i_clear` -> STOP.
- Prescaler `psc`, width `$clog2(DIV)`:
  - In RUN, increments each cycle and wraps DIV-1 -> 0.
  - In STOP, holds its value. Resume therefore continues the partial period.
  - Cleared to 0 by `i_clear` and by reset.
- Count step: occurs on the edge where state==RUN and `psc`==DIV-1.
  - Up: MAX_VAL -> 0 with wrap, else +1.
  - Down: 0 -> MAX_VAL with wrap, else -1.
- `o_count`, `o_tick`, `o_wrap` and `o_running` are all registered outputs. No combinational path from inputs to outputs.
- Simultaneous events (priority: `i_clear` > tick step > `i_run_toggle`):
  - `i_clear` + `i_run_toggle`: count=0, `psc`=0, state=STOP, no tick.
  - Tick-step cycle + `i_run_toggle` in RUN: the step is applied (uses the pre-toggle state), then state becomes STOP.
  - `i_clear` in STOP: count and `psc` zeroed, stays STOP.
- `i_dir` change mid-run takes effect at the next step. No glitch, no extra step.
- Reset asserted mid-run: all state and outputs go to reset values immediately (asynchronous). The first edge after deassert is in STOP.

## Timing
- Latency from `i_run_toggle` (sampled at edge N) to `o_running`: valid after edge N.
- First step after entering RUN from reset or clear: DIV cycles later. `o_count` changes on edge N+DIV.
- `o_tick` is high exactly for the cycle in which the new `o_count` is first visible. Period is DIV cycles while running.
- `o_wrap` is asserted only with `o_tick`.
- Pulses held longer than 1 cycle on `i_run_toggle` toggle once per high cycle. The caller supplies edge-detected pulses.

## Configuration
- `COUNTER_DOWN_EN`:
  - Defined: `i_dir` is sampled and the down/wrap-to-MAX_VAL path is built.
  - Undefined: `i_dir` is ignored (port kept, unconnected internally) and the counter is up-only.

## Test plan
Benches use SYS_CLK_HZ=10, TICK_HZ=1 (DIV=10), MAX_VAL=9999.
- Reset then `i_run_toggle` at cycle 0 -> `o_running`=1; `o_count` 0->1 with `o_tick`=1 at cycle 10; 2 at cycle 20; no tick in between.
- Force count to 9998, run 20 cycles -> 9999 then 0. `o_wrap`=1 only on the 9999->0 tick.
- Toggle stop at `psc`=4, wait 50 cycles, toggle run -> no count change while stopped; next tick 6 cycles after resume.
- `i_clear` and `i_run_toggle` same cycle while running at count 123 -> count=0, `o_running`=0, `o_tick`=0.
- With `COUNTER_DOWN_EN`, `i_dir`=1 at count 0 -> next tick gives 9999 with `o_wrap`=1. Without the macro the same stimulus gives 1, `o_wrap`=0.
- `rst_n` low asynchronously between edges while running at count 500 -> all outputs 0 before the next clock edge.
